msrv32_load_unit_ahb: RTL and testbench
=======================================

Name: msrv32_load_unit_ahb

Overview:
Parametrised, sequential load unit between the msrv32 pipeline and an AHB-Lite master port. It accepts one load request at a time, checks alignment, and runs the AHB address and data phases with wait states. It then lane-selects and sign- or zero-extends the returned data and presents a registered result with a valid pulse. Bus error responses and misaligned accesses are reported as distinct, mutually exclusive exception pulses.

Parameters:
XLEN, 32, data and address width; legal values 32 or 64.
ALLOW_MISALIGNED, 0, if 1, misaligned loads are issued to the bus unchanged and no misaligned exception is raised.

Ports:
clk_in  input  1  clock; all state updates on the rising edge.
rst_in  input  1  reset, asynchronous, active-high.
load_req_in  input  1  load request; accepted only when busy_out=0.
addr_in  input  XLEN  byte address of the load.
load_size_in  input  2  00 byte, 01 half, 10 word, 11 double (double legal only when XLEN=64).
load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
rd_tag_in  input  5  destination register tag, returned with the result.
busy_out  output  1  high in any state other than IDLE.
haddr_out  output  XLEN  AHB address.
htrans_out  output  2  AHB transfer type; IDLE=00, NONSEQ=10.
hsize_out  output  3  AHB size; equals {0, load_size_in}.
hwrite_out  output  1  tied to 0.
hrdata_in  input  XLEN  AHB read data.
hready_in  input  1  AHB ready.
hresp_in  input  1  AHB response; 1 = ERROR.
lu_valid_out  output  1  one-cycle pulse; lu_output and lu_rd_out are valid.
lu_output  output  XLEN  extended load result.
lu_rd_out  output  5  tag of the completed load.
lu_err_out  output  1  one-cycle pulse on a bus error.
lu_misaligned_out  output  1  one-cycle pulse on a misaligned request.
lu_fault_addr_out  output  XLEN  faulting address; valid with either exception pulse.

Behaviour:
- Reset: state=IDLE; htrans_out=00, haddr_out=0, hsize_out=0; lu_valid_out, lu_err_out, lu_misaligned_out=0; lu_output, lu_rd_out, lu_fault_addr_out=0. Reset asserted mid-transfer abandons the transfer and returns to IDLE with no pulse. htrans_out=00 is visible immediately, without waiting for a clock edge.
- Request capture: addr_in, size, unsigned flag and tag are registered at acceptance and held until the load completes.
- Alignment: misaligned means half with addr[0]!=0, word with addr[1:0]!=0, or double with addr[2:0]!=0. A double request when XLEN=32 is treated as misaligned.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE -> ADDR: load_req_in=1 and aligned (or ALLOW_MISALIGNED=1).
- IDLE, misaligned request with ALLOW_MISALIGNED=0: stay in IDLE. The next cycle pulses lu_misaligned_out with lu_fault_addr_out=addr_in. No bus activity occurs.
- ADDR: drives htrans_out=10 and haddr_out/hsize_out from the captured request. The state holds while hready_in=0; it moves to DATA when hready_in=1.
- DATA: drives htrans_out=00.
  - hready_in=1 and hresp_in=0: format hrdata_in into lu_output, set lu_rd_out, pulse lu_valid_out next cycle, return to IDLE.
  - hresp_in=1 and hready_in=0: go to ERR.
  - hresp_in=1 and hready_in=1: treat as an error; pulse lu_err_out next cycle and return to IDLE.
- ERR: waits for hready_in=1, then pulses lu_err_out with lu_fault_addr_out set and returns to IDLE.
- Minimum latency: a request accepted at edge 0 gives ADDR in cycle 1, DATA in cycle 2, and lu_valid_out high in cycle 3. Each wait cycle adds one cycle.
- A request arriving while busy_out=1 is ignored; the requester must hold it. A new request may be accepted in the same cycle that lu_valid_out is high.
- Formatting:
  - Lane select is by the registered address low bits.
  - Byte: lane addr[log2(XLEN/8)-1:0]*8.
  - Half: lane addr[..:1]*16.
  - Word on XLEN=64: lane addr[2]*32.
  - Full width: data passes through unchanged.
  - The upper bits are filled with the selected MSB when unsigned=0, and with 0 when unsigned=1.
  - Under ALLOW_MISALIGNED=1, a misaligned access uses the lane containing the addressed byte, with the low address bits truncated to the size boundary.
- lu_valid_out, lu_err_out and lu_misaligned_out never assert together.

Test Plan:
- XLEN=32: byte load, addr=0x1002, signed, hrdata=0x12A4_5678, no waits -> lu_valid_out in cycle 3, lu_output=0xFFFF_FFA4, tag echoed.
- Same load with load_unsigned_in=1 -> 0x0000_00A4. Half at 0x1002, signed, hrdata=0x8001_0000 -> 0xFFFF_8001.
- Word load with hready_in low for 3 cycles in ADDR and 2 cycles in DATA -> htrans_out held at 10 through ADDR, lu_valid_out in cycle 8, busy_out=1 throughout.
- Word load at 0x2001, ALLOW_MISALIGNED=0 -> htrans_out stays 00, lu_misaligned_out pulse, lu_fault_addr_out=0x2001.
- DATA phase with hresp_in=1/hready_in=0, then hresp_in=1/hready_in=1 -> ERR state, then a single lu_err_out pulse with the fault address and no lu_valid_out. Repeat with hresp_in and hready_in high together in DATA -> single lu_err_out pulse, return to IDLE.
- XLEN=64: double load at 0x8 -> full 64-bit passthrough. Word load at 0xC, signed, hrdata[63:32]=0x8000_0000 -> 0xFFFF_FFFF_8000_0000. Then assert rst_in mid-ADDR -> immediate IDLE, no pulses.

Source files
------------

// File: rtl/msrv32_load_unit_ahb.sv
// Single-outstanding load unit bridging the msrv32 pipeline to an AHB-Lite master port.
// Runs address/data phases with wait states, formats read data and reports bus/alignment faults.
module msrv32_load_unit_ahb #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load_req_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [4:0]      rd_tag_in,
  output logic            busy_out,
  output logic [XLEN-1:0] haddr_out,
  output logic [1:0]      htrans_out,
  output logic [2:0]      hsize_out,
  output logic            hwrite_out,
  input  logic [XLEN-1:0] hrdata_in,
  input  logic            hready_in,
  input  logic            hresp_in,
  output logic            lu_valid_out,
  output logic [XLEN-1:0] lu_output,
  output logic [4:0]      lu_rd_out,
  output logic            lu_err_out,
  output logic            lu_misaligned_out,
  output logic [XLEN-1:0] lu_fault_addr_out
);

  localparam int LB = $clog2(XLEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_addr;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [4:0]      r_tag;
  logic [XLEN-1:0] r_haddr;
  logic [1:0]      r_htrans;
  logic [2:0]      r_hsize;
  logic            r_valid;
  logic            r_err;
  logic            r_mis;
  logic [XLEN-1:0] r_out;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_fault;

  logic            w_mis_req;
  logic [LB-1:0]   w_lowmask;
  logic [LB-1:0]   w_off;
  logic [LB+2:0]   w_shamt;
  logic            w_full;
  logic [6:0]      w_nbits;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_top;
  logic            w_sign;
  logic [XLEN-1:0] w_fmt;

  // Double on a 32-bit datapath can never be served, so it counts as misaligned.
  always_comb begin
    w_mis_req = 1'b0;
    case (load_size_in)
      2'b00:   w_mis_req = 1'b0;
      2'b01:   w_mis_req = addr_in[0];
      2'b10:   w_mis_req = |addr_in[1:0];
      default: w_mis_req = (XLEN == 32) ? 1'b1 : |addr_in[2:0];
    endcase
  end

  // Lane offset is the registered address rounded down to the access size.
  always_comb begin
    w_lowmask = LB'((4'd1 << r_size) - 4'd1);
    w_off     = r_addr[LB-1:0] & ~w_lowmask;
    w_shamt   = {w_off, 3'b000};
    w_full    = ({1'b0, r_size} >= 3'(LB));
    w_nbits   = 7'd8 << r_size;
    w_shifted = hrdata_in >> w_shamt;
    w_mask    = w_full ? '1 : ((XLEN'(1) << w_nbits) - XLEN'(1));
    w_top     = XLEN'(1) << (w_nbits - 7'd1);
    w_sign    = |(w_shifted & w_top);
    w_fmt     = (w_shifted & w_mask) | ((!r_unsigned && w_sign) ? ~w_mask : '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_tag      <= '0;
      r_haddr    <= '0;
      r_htrans   <= 2'b00;
      r_hsize    <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_mis      <= 1'b0;
      r_out      <= '0;
      r_rd       <= '0;
      r_fault    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_mis   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_req_in) begin
            if (w_mis_req && !ALLOW_MISALIGNED) begin
              r_mis   <= 1'b1;
              r_fault <= addr_in;
            end else begin
              r_addr     <= addr_in;
              r_size     <= load_size_in;
              r_unsigned <= load_unsigned_in;
              r_tag      <= rd_tag_in;
              r_haddr    <= addr_in;
              r_hsize    <= {1'b0, load_size_in};
              r_htrans   <= 2'b10;
              r_state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (hready_in) begin
            r_htrans <= 2'b00;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (hresp_in) begin
            if (hready_in) begin
              r_err   <= 1'b1;
              r_fault <= r_addr;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ERR;
            end
          end else if (hready_in) begin
            r_out   <= w_fmt;
            r_rd    <= r_tag;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          if (hready_in) begin
            r_err   <= 1'b1;
            r_fault <= r_addr;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_out          = (r_state != S_IDLE);
  assign haddr_out         = r_haddr;
  assign htrans_out        = r_htrans;
  assign hsize_out         = r_hsize;
  assign hwrite_out        = 1'b0;
  assign lu_valid_out      = r_valid;
  assign lu_output         = r_out;
  assign lu_rd_out         = r_rd;
  assign lu_err_out        = r_err;
  assign lu_misaligned_out = r_mis;
  assign lu_fault_addr_out = r_fault;

endmodule

// File: tb/tb_msrv32_load_unit_ahb.sv
// Directed bench for the AHB load unit: a 32-bit strict instance and a 64-bit misaligned-tolerant one,
// checked against a byte-lane reference model and hand-computed results.
module tb_msrv32_load_unit_ahb;

  logic clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // instance a: XLEN=32, misaligned loads trap
  logic        req_a, uns_a, busy_a, hwrite_a, hready_a, hresp_a, valid_a, err_a, mis_a;
  logic [31:0] addr_a, haddr_a, hrdata_a, out_a, fault_a;
  logic [1:0]  size_a, htrans_a;
  logic [2:0]  hsize_a;
  logic [4:0]  tag_a, rd_a;

  // instance b: XLEN=64, misaligned loads go to the bus
  logic        req_b, uns_b, busy_b, hwrite_b, hready_b, hresp_b, valid_b, err_b, mis_b;
  logic [63:0] addr_b, haddr_b, hrdata_b, out_b, fault_b;
  logic [1:0]  size_b, htrans_b;
  logic [2:0]  hsize_b;
  logic [4:0]  tag_b, rd_b;

  msrv32_load_unit_ahb #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_a (
    .clk_in(clk), .rst_in(rst_a), .load_req_in(req_a), .addr_in(addr_a),
    .load_size_in(size_a), .load_unsigned_in(uns_a), .rd_tag_in(tag_a),
    .busy_out(busy_a), .haddr_out(haddr_a), .htrans_out(htrans_a), .hsize_out(hsize_a),
    .hwrite_out(hwrite_a), .hrdata_in(hrdata_a), .hready_in(hready_a), .hresp_in(hresp_a),
    .lu_valid_out(valid_a), .lu_output(out_a), .lu_rd_out(rd_a), .lu_err_out(err_a),
    .lu_misaligned_out(mis_a), .lu_fault_addr_out(fault_a));

  msrv32_load_unit_ahb #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .load_req_in(req_b), .addr_in(addr_b),
    .load_size_in(size_b), .load_unsigned_in(uns_b), .rd_tag_in(tag_b),
    .busy_out(busy_b), .haddr_out(haddr_b), .htrans_out(htrans_b), .hsize_out(hsize_b),
    .hwrite_out(hwrite_b), .hrdata_in(hrdata_b), .hready_in(hready_b), .hresp_in(hresp_b),
    .lu_valid_out(valid_b), .lu_output(out_b), .lu_rd_out(rd_b), .lu_err_out(err_b),
    .lu_misaligned_out(mis_b), .lu_fault_addr_out(fault_b));

  typedef struct packed {
    logic        busy;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [63:0] haddr;
    logic [2:0]  hsize;
    logic        valid;
    logic        err;
    logic        mis;
    logic [63:0] out;
    logic [4:0]  rd;
    logic [63:0] fault;
  } obs_t;

  // kind: 0 = result, 1 = bus error, 2 = misaligned
  typedef struct {
    int          w;
    int          kind;
    logic [63:0] data;
    logic [4:0]  tag;
    logic [63:0] fault;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic obs_t snap(input int w);
    obs_t o;
    if (w == 0) begin
      o.busy = busy_a; o.hwrite = hwrite_a; o.htrans = htrans_a; o.haddr = 64'(haddr_a);
      o.hsize = hsize_a; o.valid = valid_a; o.err = err_a; o.mis = mis_a;
      o.out = 64'(out_a); o.rd = rd_a; o.fault = 64'(fault_a);
    end else begin
      o.busy = busy_b; o.hwrite = hwrite_b; o.htrans = htrans_b; o.haddr = haddr_b;
      o.hsize = hsize_b; o.valid = valid_b; o.err = err_b; o.mis = mis_b;
      o.out = out_b; o.rd = rd_b; o.fault = fault_b;
    end
    return o;
  endfunction

  // Reference: gather the addressed bytes, then extend up to the datapath width.
  function automatic logic [63:0] model(input int xlen, input logic [63:0] d, input logic [63:0] a,
                                        input logic [1:0] s, input logic u);
    int          bpw;
    int          nb;
    int          base;
    logic [63:0] v;
    bpw = xlen / 8;
    nb  = 1 << s;
    if (nb > bpw) nb = bpw;
    base = (int'(a % 64'(bpw)) / nb) * nb;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(base+i) +: 8];
    if (!u && v[8*nb-1])
      for (int i = 8*nb; i < xlen; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive_req(input int w, input logic r, input logic [63:0] a, input logic [1:0] s,
                           input logic u, input logic [4:0] t);
    if (w == 0) begin
      req_a = r; addr_a = a[31:0]; size_a = s; uns_a = u; tag_a = t;
    end else begin
      req_b = r; addr_b = a; size_b = s; uns_b = u; tag_b = t;
    end
  endtask

  task automatic drive_bus(input int w, input logic rdy, input logic rsp, input logic [63:0] d);
    if (w == 0) begin
      hready_a = rdy; hresp_a = rsp; hrdata_a = d[31:0];
    end else begin
      hready_b = rdy; hresp_b = rsp; hrdata_b = d;
    end
  endtask

  // Called at a negedge with the DUT idle. aw/dw are ADDR/DATA wait cycles; with err the
  // data phase answers ERROR (dw=0 gives hresp and hready together).
  task automatic run_load(input int w, input logic [63:0] a, input logic [1:0] s, input logic u,
                          input logic [4:0] t, input logic [63:0] d, input int aw, input int dw,
                          input logic err, input logic [63:0] lit);
    exp_t e;
    obs_t o;
    e.w     = w;
    e.kind  = err ? 1 : 0;
    e.data  = err ? 64'd0 : model((w == 0) ? 32 : 64, d, a, s, u);
    e.tag   = t;
    e.fault = a;
    e.cyc   = cyc + 3 + aw + dw;
    exp_q.push_back(e);
    drive_req(w, 1'b1, a, s, u, t);
    drive_bus(w, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    drive_req(w, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0);
    o = snap(w);
    check("addr_htrans", 64'(o.htrans), 64'h2);
    check("addr_haddr", o.haddr, a);
    check("addr_hsize", 64'(o.hsize), 64'({1'b0, s}));
    check("addr_busy", 64'(o.busy), 64'h1);
    for (int i = 0; i < aw; i++) begin
      drive_bus(w, 1'b0, 1'b0, 64'd0);
      @(negedge clk);
      o = snap(w);
      check("addr_hold_htrans", 64'(o.htrans), 64'h2);
      check("addr_hold_busy", 64'(o.busy), 64'h1);
    end
    drive_bus(w, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    o = snap(w);
    check("data_htrans", 64'(o.htrans), 64'h0);
    check("data_busy", 64'(o.busy), 64'h1);
    for (int i = 0; i < dw; i++) begin
      drive_bus(w, 1'b0, err, 64'd0);
      @(negedge clk);
      o = snap(w);
      check("wait_busy", 64'(o.busy), 64'h1);
      check("wait_htrans", 64'(o.htrans), 64'h0);
    end
    drive_bus(w, 1'b1, err, d);
    @(negedge clk);
    drive_bus(w, 1'b1, 1'b0, 64'd0);
    o = snap(w);
    if (err) begin
      check("err_pulse", 64'(o.err), 64'h1);
      check("err_fault_addr", o.fault, a);
      check("err_no_valid", 64'(o.valid), 64'h0);
    end else begin
      check("valid_pulse", 64'(o.valid), 64'h1);
      check("result_literal", o.out, lit);
      check("result_tag", 64'(o.rd), 64'(t));
    end
    check("done_busy", 64'(o.busy), 64'h0);
  endtask

  task automatic run_mis(input int w, input logic [63:0] a, input logic [1:0] s, input logic [4:0] t);
    exp_t e;
    obs_t o;
    e.w = w; e.kind = 2; e.data = 64'd0; e.tag = t; e.fault = a; e.cyc = cyc + 1;
    exp_q.push_back(e);
    drive_req(w, 1'b1, a, s, 1'b0, t);
    @(negedge clk);
    drive_req(w, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0);
    o = snap(w);
    check("mis_pulse", 64'(o.mis), 64'h1);
    check("mis_fault_addr", o.fault, a);
    check("mis_htrans", 64'(o.htrans), 64'h0);
    check("mis_busy", 64'(o.busy), 64'h0);
    @(negedge clk);
    o = snap(w);
    check("mis_single_pulse", 64'(o.mis), 64'h0);
    check("mis_htrans_after", 64'(o.htrans), 64'h0);
  endtask

  // scoreboard: every cycle, every pulse must match the head of the expected queue
  always @(negedge clk) begin : cmp
    obs_t o;
    exp_t e;
    int   n;
    int   k;
    for (int w = 0; w < 2; w++) begin
      if ((w == 0) ? !rst_a : !rst_b) begin
        o = snap(w);
        n = int'(o.valid) + int'(o.err) + int'(o.mis);
        if (n > 1) check("pulse_exclusive", 64'(n), 64'd1);
        if (n >= 1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 64'({o.valid, o.err, o.mis}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            k = o.valid ? 0 : (o.err ? 1 : 2);
            check("sb_instance", 64'(w), 64'(e.w));
            check("sb_kind", 64'(k), 64'(e.kind));
            check("sb_cycle", 64'(cyc), 64'(e.cyc));
            if (e.kind == 0) begin
              check("sb_data", o.out, e.data);
              check("sb_tag", 64'(o.rd), 64'(e.tag));
            end else begin
              check("sb_fault", o.fault, e.fault);
            end
          end
        end
      end
    end
  end

  initial begin
    obs_t o;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_req(0, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0);
    drive_req(1, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0);
    drive_bus(0, 1'b1, 1'b0, 64'd0);
    drive_bus(1, 1'b1, 1'b0, 64'd0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      o = snap(w);
      check("rst_busy", 64'(o.busy), 64'd0);
      check("rst_htrans", 64'(o.htrans), 64'd0);
      check("rst_haddr", o.haddr, 64'd0);
      check("rst_hsize", 64'(o.hsize), 64'd0);
      check("rst_hwrite", 64'(o.hwrite), 64'd0);
      check("rst_pulses", 64'({o.valid, o.err, o.mis}), 64'd0);
      check("rst_out", o.out, 64'd0);
      check("rst_rd", 64'(o.rd), 64'd0);
      check("rst_fault", o.fault, 64'd0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // XLEN=32 loads
    run_load(0, 64'h1002, 2'b00, 1'b0, 5'd5,  64'h12A4_5678, 0, 0, 1'b0, 64'hFFFF_FFA4);
    run_load(0, 64'h1002, 2'b00, 1'b1, 5'd6,  64'h12A4_5678, 0, 0, 1'b0, 64'h0000_00A4);
    run_load(0, 64'h1002, 2'b01, 1'b0, 5'd7,  64'h8001_0000, 0, 0, 1'b0, 64'hFFFF_8001);
    run_load(0, 64'h1004, 2'b10, 1'b0, 5'd8,  64'hDEAD_BEEF, 3, 2, 1'b0, 64'hDEAD_BEEF);
    run_load(0, 64'h1003, 2'b00, 1'b0, 5'd9,  64'h7F12_3456, 0, 1, 1'b0, 64'h0000_007F);
    run_load(0, 64'h1000, 2'b01, 1'b1, 5'd10, 64'h1234_F00D, 1, 0, 1'b0, 64'h0000_F00D);
    run_mis(0, 64'h2001, 2'b10, 5'd11);
    run_mis(0, 64'h2003, 2'b01, 5'd12);
    run_mis(0, 64'h2000, 2'b11, 5'd13);
    run_load(0, 64'h3000, 2'b10, 1'b0, 5'd14, 64'h0, 0, 1, 1'b1, 64'h0);
    run_load(0, 64'h3004, 2'b10, 1'b0, 5'd15, 64'h0, 0, 0, 1'b1, 64'h0);
    run_load(0, 64'h3008, 2'b10, 1'b0, 5'd16, 64'h0, 1, 3, 1'b1, 64'h0);

    // XLEN=64 loads
    run_load(1, 64'h8, 2'b11, 1'b0, 5'd17, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0, 64'h0123_4567_89AB_CDEF);
    run_load(1, 64'hC, 2'b10, 1'b0, 5'd18, 64'h8000_0000_1234_5678, 0, 0, 1'b0, 64'hFFFF_FFFF_8000_0000);
    run_load(1, 64'hF, 2'b00, 1'b0, 5'd19, 64'h8500_0000_0000_0000, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FF85);
    run_load(1, 64'h3, 2'b01, 1'b1, 5'd20, 64'h0000_0000_BEEF_0000, 0, 0, 1'b0, 64'h0000_0000_0000_BEEF);
    run_load(1, 64'h6, 2'b10, 1'b0, 5'd21, 64'h1122_3344_5566_7788, 2, 0, 1'b0, 64'h0000_0000_1122_3344);
    run_load(1, 64'h4, 2'b10, 1'b0, 5'd22, 64'hCAFE_F00D_0000_0000, 1, 1, 1'b0, 64'hFFFF_FFFF_CAFE_F00D);

    // reset in the middle of an address phase abandons the load silently
    drive_req(1, 1'b1, 64'h40, 2'b10, 1'b0, 5'd23);
    @(negedge clk);
    drive_req(1, 1'b0, 64'd0, 2'b00, 1'b0, 5'd0);
    drive_bus(1, 1'b0, 1'b0, 64'd0);
    o = snap(1);
    check("pre_rst_htrans", 64'(o.htrans), 64'h2);
    #2 rst_b = 1'b1;
    #1 o = snap(1);
    check("async_rst_htrans", 64'(o.htrans), 64'h0);
    check("async_rst_busy", 64'(o.busy), 64'h0);
    @(negedge clk);
    rst_b = 1'b0;
    drive_bus(1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (4) @(negedge clk);
    o = snap(1);
    check("post_rst_busy", 64'(o.busy), 64'h0);
    check("post_rst_out", o.out, 64'h0);
    check("post_rst_rd", 64'(o.rd), 64'h0);
    run_load(1, 64'h10, 2'b01, 1'b0, 5'd24, 64'h0000_0000_0000_7FFF, 0, 0, 1'b0, 64'h0000_0000_0000_7FFF);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
